div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width; every value in this document is for WIDTH=32.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, the request pulse from the control unit.
REQ-005 SHALL have port A, input, WIDTH bits, the signed dividend, sampled only on an accepted start.
REQ-006 SHALL have port B, input, WIDTH bits, the signed divisor, sampled only on an accepted start.
REQ-007 SHALL have port HI, output, WIDTH bits, the signed remainder.
REQ-008 SHALL have port LO, output, WIDTH bits, the signed quotient.
REQ-009 SHALL have port busy, output, 1 bit, high while a division is running.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse when HI/LO are updated.
REQ-011 SHALL have port div_zero, output, 1 bit, a one-cycle pulse when a start is rejected because B==0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and FINISH, registered outputs only.
REQ-013 IDLE, start=1, B!=0 SHALL be the accepted start: latch |A|, |B| and the two sign bits, clear the remainder register and the counter, go to RUN, busy=1 next cycle.
REQ-014 IDLE, start=1, B==0 SHALL pulse div_zero for one cycle in the next cycle, stay in IDLE, leave busy=0 and leave HI/LO unchanged.
REQ-015 RUN SHALL perform one restoring step per cycle: shift {rem,quot} left by 1, subtract |B| from rem, keep the result and set the quotient LSB to 1 if it is non-negative, else restore and set the LSB to 0.
REQ-016 The counter SHALL run 0..WIDTH-1; after step WIDTH-1 the FSM SHALL move to FINISH.
REQ-017 FINISH SHALL write LO = quotient, negated if the sign of A differs from the sign of B, and HI = remainder, negated if A is negative.
REQ-018 FINISH SHALL assert done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge N gives done high and new HI/LO valid in the cycle after edge N+WIDTH+1, i.e. 33 cycles for WIDTH=32, independent of the operands.
REQ-020 start while in RUN or FINISH SHALL be ignored, with no queuing and no effect on the running operation.
REQ-021 HI/LO SHALL hold their value between completed divisions.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no flag.
REQ-023 Magnitudes SHALL be handled as WIDTH-bit unsigned values so |0x80000000| is represented exactly; the internal remainder SHALL be WIDTH+1 bits.
REQ-024 A==0 with B!=0 SHALL complete normally with LO=0 and HI=0.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, and clear the counter and internal registers.
REQ-026 reset SHALL take priority over start and over any state, aborting a running division with no done pulse.
REQ-027 The first cycle after reset is released SHALL accept a start.

Verification
REQ-028 A=100, B=7, start pulse -> busy high for 32 cycles, done at +33, LO=14, HI=2.
REQ-029 A=-100, B=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE; A=100, B=-7 -> LO=0xFFFFFFF2, HI=2.
REQ-030 A=5, B=0 -> div_zero pulses one cycle, busy stays 0, done stays 0, HI/LO keep their previous values.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0 at +33.
REQ-032 start A=100, B=7 with a second start (A=9, B=3) at cycle +5 -> second start ignored, result LO=14, HI=2.
REQ-033 reset at cycle +10 of a run -> HI=LO=0, busy=0, no done pulse; the next start (A=9, B=3) gives LO=3, HI=0 at +33.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle for the sequential signed divider.
// The control unit drives start/A/B; the divider returns HI/LO and status pulses.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, A, B,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider, one quotient bit per clock, fixed WIDTH+1 cycle latency.
// Works on magnitudes and fixes the result signs when the run completes.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_babs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH:0]   r_rem;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    // Magnitude as unsigned: the most negative value maps onto itself, which is exact.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // The remainder stays below |B| <= 2^WIDTH, so a WIDTH+2 bit difference has a valid sign bit.
    assign w_rem_sh = {r_rem, r_quot[WIDTH-1]};
    assign w_diff   = w_rem_sh - {2'b00, r_babs};
    assign w_fits   = ~w_diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_babs     <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.B == '0) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_babs   <= f_abs(bus.B);
                            r_quot   <= f_abs(bus.A);
                            r_sign_a <= bus.A[WIDTH-1];
                            r_sign_b <= bus.B[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem  <= w_fits ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    // Quotient sign follows the operand signs; remainder follows the dividend.
                    r_lo    <= f_neg_if(r_quot, r_sign_a ^ r_sign_b);
                    r_hi    <= f_neg_if(r_rem[WIDTH-1:0], r_sign_a);
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands against an
// arithmetic reference built on 64-bit signed division.
module tb_div_unit;
    localparam int W = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating signed division, results wrapped to W bits.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa - lq * sb;
        q  = lq[W-1:0];
        r  = lr[W-1:0];
    endtask

    // Called at a negedge; start is seen at the next posedge (edge N).
    // inj_at >= 0 issues a second start (9/3) while the first one is running.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_at, input string tag);
        int k;
        int busy_cyc;
        bit seen;
        logic [W-1:0] q, r;
        logic [W-1:0] prev_lo;
        ref_div(a, b, q, r);
        prev_lo = exp_lo;
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_on"}, W'(bus.busy), W'(1));
        chk({tag, "_lo_hold"}, bus.LO, prev_lo);
        k = 0;
        busy_cyc = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cyc++;
                bus.start = (k == inj_at);
                if (k == inj_at) begin
                    bus.A = 32'd9;
                    bus.B = 32'd3;
                end
                @(negedge clk);
                bus.start = 1'b0;
                k++;
            end
        end
        exp_lo = q;
        exp_hi = r;
        chk({tag, "_latency"}, W'(k), W'(LAT));
        chk({tag, "_busy_cycles"}, W'(busy_cyc), W'(W));
        chk({tag, "_LO"}, bus.LO, exp_lo);
        chk({tag, "_HI"}, bus.HI, exp_hi);
        @(negedge clk);
        chk({tag, "_done_pulse"}, W'(bus.done), W'(0));
        chk({tag, "_LO_after"}, bus.LO, exp_lo);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_HI", bus.HI, '0);
        chk("rst_LO", bus.LO, '0);
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_divzero", W'(bus.div_zero), W'(0));
        reset = 1'b0;

        // Issued in the first cycle after reset release.
        do_div(32'd100, 32'd7, -1, "pos_pos");
        do_div(-32'sd100, 32'd7, -1, "neg_pos");
        do_div(32'd100, -32'sd7, -1, "pos_neg");
        chk("neg_pos_const", exp_lo, 32'hFFFF_FFF2);

        // Divide by zero: rejected, results untouched.
        bus.start = 1'b1;
        bus.A = 32'd5;
        bus.B = '0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("dz_pulse", W'(bus.div_zero), W'(1));
        chk("dz_busy", W'(bus.busy), W'(0));
        chk("dz_done", W'(bus.done), W'(0));
        chk("dz_HI", bus.HI, exp_hi);
        chk("dz_LO", bus.LO, exp_lo);
        @(negedge clk);
        chk("dz_pulse_end", W'(bus.div_zero), W'(0));
        chk("dz_busy2", W'(bus.busy), W'(0));

        do_div(32'h8000_0000, 32'hFFFF_FFFF, -1, "ovf_wrap");
        chk("ovf_LO_const", bus.LO, 32'h8000_0000);
        do_div(32'd0, 32'd13, -1, "zero_dividend");
        do_div(32'd100, 32'd7, 5, "ignored_start");
        do_div(32'h7FFF_FFFF, 32'h8000_0000, -1, "max_by_min");
        do_div(32'h8000_0000, 32'h8000_0000, -1, "min_by_min");

        // Reset in the middle of a run aborts it without a done pulse.
        bus.start = 1'b1;
        bus.A = 32'd100;
        bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", W'(bus.busy), W'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_HI", bus.HI, '0);
        chk("abort_LO", bus.LO, '0);
        chk("abort_busy", W'(bus.busy), W'(0));
        chk("abort_done", W'(bus.done), W'(0));
        exp_hi = '0;
        exp_lo = '0;
        reset = 1'b0;
        do_div(32'd9, 32'd3, -1, "after_abort");

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            if (i % 3 == 0) rb = -rb;
            if (rb == '0) rb = 32'd1;
            do_div(ra, rb, (i == 4) ? 12 : -1, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
